// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: source count, register
// map, GEN bit position and controller state encoding.
package irq_ctrl_pkg;

  localparam int unsigned NSRC    = 6;
  localparam int unsigned IDW     = 3;
  localparam int unsigned GEN_BIT = 8;

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;
  localparam logic [1:0] A_ISR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder: index 0 has the highest priority.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0]   req,
  output logic           any,
  output logic [IDW-1:0] id
);

  always_comb begin
    any = 1'b0;
    id  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !any) begin
        any = 1'b1;
        id  = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: mask/pending/mode registers, edge or level sampling,
// fixed-priority selection and a non-preemptive IDLE/ACTIVE/GAP service FSM.
module irq_ctrl #(
  parameter int unsigned NSRC = irq_ctrl_pkg::NSRC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  input  logic [NSRC-1:0] irq_src,
  output logic [NSRC-1:0] imout,
  output logic            irq
);
  import irq_ctrl_pkg::*;

  logic [NSRC-1:0] mask, mode, pend, prev;
  logic [NSRC-1:0] pend_n, w1c, eoi_clr, eligible, imout_d;
  logic            gen;
  logic [IDW-1:0]  id, id_n, enc_id;
  logic            enc_any, eoi, irq_d;
  state_t          state, state_n;

  logic unused_din;
  assign unused_din = ^{din[31:GEN_BIT+1], din[GEN_BIT-1:NSRC]};

  assign eoi      = we && (addr == A_ISR);
  assign w1c      = (we && (addr == A_PEND)) ? din[NSRC-1:0] : '0;
  assign eligible = pend & mask & {NSRC{gen}};

  irq_prio_enc #(.N(NSRC)) u_enc (
    .req (eligible),
    .any (enc_any),
    .id  (enc_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
      mode <= '0;
      gen  <= 1'b0;
    end else if (we) begin
      if (addr == A_MASK) mask <= din[NSRC-1:0];
      if (addr == A_MODE) begin
        mode <= din[NSRC-1:0];
        gen  <= din[GEN_BIT];
      end
    end
  end

  always_comb begin
    eoi_clr = '0;
    if (state == ST_ACTIVE && eoi) eoi_clr[id] = 1'b1;
  end

  // Level bits track the line; edge bits clear on W1C/EOI but a same-cycle edge wins.
  always_comb begin
    pend_n = pend;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!mode[i]) begin
        pend_n[i] = irq_src[i];
      end else begin
        if (w1c[i] || eoi_clr[i]) pend_n[i] = 1'b0;
        if (irq_src[i] && !prev[i]) pend_n[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      prev <= '0;
    end else begin
      pend <= pend_n;
      prev <= irq_src;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (enc_any) state_n = ST_ACTIVE;
      ST_ACTIVE: if (eoi)     state_n = ST_GAP;
      ST_GAP:                 state_n = ST_IDLE;
      default:                state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so irq follows the decision by one clock.
  always_comb begin
    id_n    = (state == ST_IDLE && enc_any) ? enc_id : id;
    imout_d = '0;
    irq_d   = (state_n == ST_ACTIVE);
    if (state_n == ST_ACTIVE) imout_d[id_n] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id    <= '0;
      imout <= '0;
      irq   <= 1'b0;
    end else begin
      id    <= id_n;
      imout <= imout_d;
      irq   <= irq_d;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      A_MASK: dout[NSRC-1:0] = mask;
      A_PEND: dout[NSRC-1:0] = pend;
      A_MODE: begin
        dout[NSRC-1:0] = mode;
        dout[GEN_BIT]  = gen;
      end
      default: begin
        dout[31]      = (state == ST_ACTIVE);
        dout[IDW-1:0] = id;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl: one task per scenario with hand-computed expectations.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [5:0]  irq_src = '0;
  logic [5:0]  imout;
  logic        irq;

  int tests = 0;
  int fails = 0;

  irq_ctrl #(.NSRC(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .irq_src (irq_src),
    .imout   (imout),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    din  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (irq !== 1'b0 || imout !== 6'h00) begin
      fails++;
      $display("FAIL reset_out: irq=%b imout=%h, want 0/00", irq, imout);
    end
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      tests++;
      if (d !== 32'h0) begin
        fails++;
        $display("FAIL reset_reg%0d: got %h want 00000000", i, d);
      end
    end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    wr(A_MASK, 32'h01);
    wr(A_MODE, 32'h101);
    irq_src = 6'h01;
    tick();
    irq_src = 6'h00;
    rd(A_PEND, d);
    tests++;
    if (d !== 32'h01 || irq !== 1'b0) begin
      fails++;
      $display("FAIL edge_pend: pend=%h irq=%b, want 01/0", d, irq);
    end
    tick();
    tests++;
    if (irq !== 1'b1 || imout !== 6'h01) begin
      fails++;
      $display("FAIL edge_irq: irq=%b imout=%h, want 1/01", irq, imout);
    end
    rd(A_ISR, d);
    tests++;
    if (d !== 32'h8000_0000) begin
      fails++;
      $display("FAIL edge_isr: got %h want 80000000", d);
    end
    wr(A_ISR, 32'h0);
    rd(A_PEND, d);
    tests++;
    if (irq !== 1'b0 || imout !== 6'h00 || d !== 32'h0) begin
      fails++;
      $display("FAIL edge_eoi: irq=%b imout=%h pend=%h, want 0/00/0", irq, imout, d);
    end
    tick();
    tick();
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL edge_noretrig: irq=%b want 0", irq);
    end
  endtask

  task automatic test_priority();
    wr(A_MASK, 32'h3F);
    wr(A_MODE, 32'h13F);
    irq_src = 6'h12;
    tick();
    irq_src = 6'h00;
    tick();
    tests++;
    if (imout !== 6'h02) begin
      fails++;
      $display("FAIL prio_first: imout=%h want 02", imout);
    end
    wr(A_ISR, 32'h0);
    tests++;
    if (irq !== 1'b0 || imout !== 6'h00) begin
      fails++;
      $display("FAIL prio_gap: irq=%b imout=%h want 0/00", irq, imout);
    end
    tick();
    tick();
    tests++;
    if (imout !== 6'h10 || irq !== 1'b1) begin
      fails++;
      $display("FAIL prio_second: imout=%h irq=%b want 10/1", imout, irq);
    end
    wr(A_ISR, 32'h0);
    tick();
  endtask

  task automatic test_no_preempt();
    logic [31:0] d;
    irq_src = 6'h08;
    tick();
    irq_src = 6'h00;
    tick();
    irq_src = 6'h01;
    tick();
    irq_src = 6'h00;
    tick();
    rd(A_PEND, d);
    tests++;
    if (imout !== 6'h08 || d !== 32'h09) begin
      fails++;
      $display("FAIL nopre_hold: imout=%h pend=%h want 08/09", imout, d);
    end
    rd(A_ISR, d);
    tests++;
    if (d !== 32'h8000_0003) begin
      fails++;
      $display("FAIL nopre_isr: got %h want 80000003", d);
    end
    wr(A_ISR, 32'h0);
    tick();
    tick();
    tests++;
    if (imout !== 6'h01) begin
      fails++;
      $display("FAIL nopre_next: imout=%h want 01", imout);
    end
    wr(A_ISR, 32'h0);
    tick();
  endtask

  task automatic test_level_mask();
    logic [31:0] d;
    wr(A_MASK, 32'h00);
    wr(A_MODE, 32'h100);
    irq_src = 6'h20;
    tick();
    tick();
    rd(A_PEND, d);
    tests++;
    if (d !== 32'h20 || irq !== 1'b0) begin
      fails++;
      $display("FAIL lvl_masked: pend=%h irq=%b want 20/0", d, irq);
    end
    wr(A_MASK, 32'h20);
    tick();
    tests++;
    if (irq !== 1'b1 || imout !== 6'h20) begin
      fails++;
      $display("FAIL lvl_unmask: irq=%b imout=%h want 1/20", irq, imout);
    end
    wr(A_PEND, 32'h20);
    wr(A_MASK, 32'h00);
    rd(A_PEND, d);
    tests++;
    if (d !== 32'h20 || irq !== 1'b1) begin
      fails++;
      $display("FAIL lvl_w1c_mask: pend=%h irq=%b want 20/1", d, irq);
    end
    wr(A_MASK, 32'h20);
    irq_src = 6'h00;
    tick();
    wr(A_ISR, 32'h0);
    tick();
    tick();
    tick();
    rd(A_PEND, d);
    tests++;
    if (irq !== 1'b0 || d !== 32'h0) begin
      fails++;
      $display("FAIL lvl_noretrig: irq=%b pend=%h want 0/0", irq, d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    wr(A_MASK, 32'h00);
    wr(A_MODE, 32'h104);
    irq_src = 6'h04;
    addr = A_PEND;
    din  = 32'h04;
    we   = 1'b1;
    tick();
    we = 1'b0;
    irq_src = 6'h00;
    rd(A_PEND, d);
    tests++;
    if (d !== 32'h04) begin
      fails++;
      $display("FAIL collide_set: pend=%h want 04", d);
    end
    wr(A_PEND, 32'h04);
    rd(A_PEND, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL collide_w1c: pend=%h want 00", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(A_MASK, 32'h04);
    irq_src = 6'h04;
    tick();
    irq_src = 6'h00;
    tick();
    tests++;
    if (irq !== 1'b1 || imout !== 6'h04) begin
      fails++;
      $display("FAIL rstmid_active: irq=%b imout=%h want 1/04", irq, imout);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (irq !== 1'b0 || imout !== 6'h00) begin
      fails++;
      $display("FAIL rstmid_async: irq=%b imout=%h want 0/00", irq, imout);
    end
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      tests++;
      if (d !== 32'h0) begin
        fails++;
        $display("FAIL rstmid_reg%0d: got %h want 00000000", i, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_priority();
    test_no_preempt();
    test_level_mask();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
